text_writer: RTL and testbench
==============================

TEXT_WRITER -- requirements
Module: text_writer

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: wr_valid  input  1  producer offers wr_data this cycle.
REQ-004 SHALL have port: wr_ready  output  1  block accepts wr_data this cycle.
REQ-005 SHALL have port: wr_data  input  8  ASCII code offered by producer.
REQ-006 SHALL have port: rd_index  input  4  character-cell index from display side.
REQ-007 SHALL have port: rd_ascii  output  8  ASCII code stored at rd_index, registered.
REQ-008 SHALL have port: cursor  output  5  next write position, 0..16.
REQ-009 SHALL have port: overflow  output  1  sticky, printable character dropped.
REQ-010 SHALL have parameter: none; buffer depth fixed at 16 cells of 8 bits.

Function
REQ-011 SHALL implement a two-state FSM: CLEAR, IDLE.
REQ-012 CLEAR SHALL write 0x00 to cells 0..15, one cell per cycle, in ascending order (16 cycles), with wr_ready=0, then go to IDLE.
REQ-013 IDLE SHALL drive wr_ready=1; a transfer occurs on a cycle where wr_valid=1 and wr_ready=1.
REQ-014 Printable transfer (0x20..0x7E) with cursor<16 SHALL write wr_data to cell[cursor] and increment cursor.
REQ-015 Printable transfer with cursor==16 SHALL be governed by REQ-027/REQ-028.
REQ-016 Backspace transfer (0x08) with cursor>0 SHALL decrement cursor and write 0x00 to cell[cursor-1]; with cursor==0 SHALL be accepted and ignored.
REQ-017 Form-feed transfer (0x0C) SHALL set cursor=0, clear overflow and enter CLEAR next cycle.
REQ-018 Any other code (0x00..0x1F except 0x08/0x0C, 0x7F..0xFF) SHALL be accepted and ignored.
REQ-019 rd_ascii SHALL equal cell[rd_index] sampled at the previous rising edge (1-cycle latency), in both states.
REQ-020 Same-cycle write and read of one cell SHALL return the pre-write value (read-before-write).
REQ-021 cursor SHALL never exceed 16 and never go below 0.
REQ-022 overflow SHALL remain 1 once set until reset or form feed.

Reset
REQ-023 reset=1 at a rising edge SHALL set state=CLEAR, clear-counter=0, cursor=0, overflow=0, rd_ascii=0x00, wr_ready=0.
REQ-024 reset asserted mid-CLEAR SHALL restart clearing from cell 0; reset asserted mid-IDLE SHALL discard any concurrent transfer.
REQ-025 After reset deasserts, wr_ready SHALL rise exactly 16 cycles later.
REQ-026 Cell contents SHALL be defined only via CLEAR, not by reset directly.

Configuration
REQ-027 With TEXT_WRAP_EN undefined: printable transfer at cursor==16 SHALL be accepted, discarded, set overflow=1, leave cursor=16.
REQ-028 With TEXT_WRAP_EN defined: printable transfer at cursor==16 SHALL write cell[0], set cursor=1, leave overflow unchanged (always 0).

Verification
REQ-029 Reset 1 cycle, then wr_valid=1 constantly -> wr_ready=0 for 16 cycles, 1 on the 17th; all cells read 0x00.
REQ-030 Send 'A','l','e','x','!' (0x41,0x6C,0x65,0x78,0x21) -> cursor=5; rd_index 0..4 return those codes one cycle later; cell 5 returns 0x00.
REQ-031 After REQ-030, send 0x08 twice -> cursor=3, cells 3,4 read 0x00; then 0x08 at cursor 0 (after 3 more) -> cursor stays 0.
REQ-032 Send 17 printable 0x30 -> without TEXT_WRAP_EN: cursor=16, overflow=1, cell 0=0x30; with TEXT_WRAP_EN: cursor=1, overflow=0, cell 0=0x30.
REQ-033 Send 0x0C at cursor 7 with overflow=1 -> cursor=0, overflow=0, wr_ready=0 for 16 cycles, all cells 0x00; 0x0A sent afterwards -> no change.
REQ-034 Assert reset at CLEAR cycle 8 -> wr_ready stays 0 for a fresh 16 cycles after deassertion.

Source files
------------

// File: rtl/text_writer_if.sv
// text_writer_if -- bundles the producer write handshake and the display-side
// read port of the text_writer character buffer.
//   wr_valid  producer offers wr_data this cycle
//   wr_ready  buffer accepts wr_data this cycle
//   wr_data   ASCII code offered by the producer
//   rd_index  character-cell index requested by the display side
//   rd_ascii  registered ASCII code of cell rd_index
//   cursor    next write position, 0..16
//   overflow  sticky flag: a printable character was dropped
// master = producer/display side, slave = text_writer.
interface text_writer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic [3:0] rd_index;
  logic [7:0] rd_ascii;
  logic [4:0] cursor;
  logic       overflow;

  modport master (
    output wr_valid, wr_data, rd_index,
    input  wr_ready, rd_ascii, cursor, overflow
  );

  modport slave (
    input  wr_valid, wr_data, rd_index,
    output wr_ready, rd_ascii, cursor, overflow
  );
endinterface

// File: rtl/text_writer.sv
// text_writer -- 16-cell x 8-bit text line buffer with a write cursor.
// After reset (or a form feed) the buffer spends 16 cycles zeroing cells 0..15
// in the CLEAR state, then accepts characters in IDLE:
//   0x20..0x7E  printable: stored at cell[cursor], cursor advances
//   0x08        backspace: cursor retreats and the vacated cell is zeroed
//   0x0C        form feed: cursor=0, overflow cleared, buffer re-cleared
//   others      accepted and ignored
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    text_writer_if.slave (write handshake, read port, cursor, overflow)
// Configuration macro TEXT_WRAP_EN:
//   undefined -> a printable character at cursor 16 is dropped and sets overflow
//   defined   -> a printable character at cursor 16 wraps to cell 0, cursor=1
// Cell storage has no reset; its contents become defined only through CLEAR.
module text_writer (
  input  logic         clk,
  input  logic         reset,
  text_writer_if.slave bus
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] clr_cnt_q, clr_cnt_d;
  logic [4:0] cursor_q, cursor_d;
  logic       overflow_q, overflow_d;
  logic [7:0] rd_ascii_q;
  logic [7:0] mem_q [16];

  logic       xfer_s;
  logic       printable_s;
  logic [4:0] cursor_dec_s;
  logic       we_s;
  logic [3:0] waddr_s;
  logic [7:0] wdata_s;

  assign bus.wr_ready = (state_q == ST_IDLE);
  assign bus.rd_ascii = rd_ascii_q;
  assign bus.cursor   = cursor_q;
  assign bus.overflow = overflow_q;

  assign xfer_s       = bus.wr_valid && (state_q == ST_IDLE);
  assign printable_s  = (bus.wr_data >= 8'h20) && (bus.wr_data <= 8'h7E);
  assign cursor_dec_s = cursor_q - 5'd1;

  // Next-state, cursor/overflow update and the single cell write port.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    cursor_d   = cursor_q;
    overflow_d = overflow_q;
    we_s       = 1'b0;
    waddr_s    = 4'd0;
    wdata_s    = 8'h00;
    case (state_q)
      ST_CLEAR: begin
        we_s      = 1'b1;
        waddr_s   = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + 4'd1;
        if (clr_cnt_q == 4'd15) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        if (xfer_s) begin
          if (printable_s) begin
            if (cursor_q < 5'd16) begin
              we_s     = 1'b1;
              waddr_s  = cursor_q[3:0];
              wdata_s  = bus.wr_data;
              cursor_d = cursor_q + 5'd1;
            end else begin
`ifdef TEXT_WRAP_EN
              we_s     = 1'b1;
              waddr_s  = 4'd0;
              wdata_s  = bus.wr_data;
              cursor_d = 5'd1;
`else
              overflow_d = 1'b1;
`endif
            end
          end else if (bus.wr_data == 8'h08) begin
            if (cursor_q != 5'd0) begin
              cursor_d = cursor_dec_s;
              we_s     = 1'b1;
              waddr_s  = cursor_dec_s[3:0];
            end else begin
              cursor_d = 5'd0;
            end
          end else if (bus.wr_data == 8'h0C) begin
            cursor_d   = 5'd0;
            overflow_d = 1'b0;
            clr_cnt_d  = 4'd0;
            state_d    = ST_CLEAR;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = 4'd0;
      end
    endcase
  end

  // Control state and registered read port; reset discards any transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= 4'd0;
      cursor_q   <= 5'd0;
      overflow_q <= 1'b0;
      rd_ascii_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      cursor_q   <= cursor_d;
      overflow_q <= overflow_d;
      // Nonblocking read of the old cell value gives read-before-write.
      rd_ascii_q <= mem_q[bus.rd_index];
    end
  end

  // Cell storage write port, suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (!reset && we_s) begin
      mem_q[waddr_s] <= wdata_s;
    end
  end

endmodule

// File: tb/tb_text_writer.sv
// tb_text_writer -- self-checking bench for text_writer.
// A behavioural model of the buffer runs alongside the DUT; each cycle the
// expected rd_ascii is pushed to a scoreboard queue before the edge and popped
// and compared after it, while wr_ready, cursor and overflow are compared every
// cycle. Directed sequences cover reset/clear timing, printable text,
// backspace, cursor-16 behaviour (TEXT_WRAP_EN aware), form feed and reset
// during clearing.
module tb_text_writer;
  logic clk = 1'b0;
  logic reset = 1'b1;

  text_writer_if bus();

  text_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [7:0] m_mem   [16];
  bit         m_known [16];
  bit         m_clear;
  int         m_cnt;
  int         m_cur;
  bit         m_ovf;

  int exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
  endtask

  // Advance one clock: update the model with the inputs present at the edge,
  // then compare every output against it.
  task automatic tick();
    logic [7:0] d;
    int got;
    if (reset) exp_q.push_back(0);
    else if (m_known[bus.rd_index]) exp_q.push_back(int'(m_mem[bus.rd_index]));
    else exp_q.push_back(-1);

    if (reset) begin
      m_clear = 1'b1; m_cnt = 0; m_cur = 0; m_ovf = 1'b0;
    end else if (m_clear) begin
      m_mem[m_cnt] = 8'h00; m_known[m_cnt] = 1'b1;
      if (m_cnt == 15) m_clear = 1'b0;
      m_cnt = (m_cnt + 1) % 16;
    end else if (bus.wr_valid) begin
      d = bus.wr_data;
      if (d >= 8'h20 && d <= 8'h7E) begin
        if (m_cur < 16) begin
          m_mem[m_cur] = d; m_known[m_cur] = 1'b1; m_cur++;
        end else begin
`ifdef TEXT_WRAP_EN
          m_mem[0] = d; m_known[0] = 1'b1; m_cur = 1;
`else
          m_ovf = 1'b1;
`endif
        end
      end else if (d == 8'h08) begin
        if (m_cur > 0) begin
          m_cur--; m_mem[m_cur] = 8'h00; m_known[m_cur] = 1'b1;
        end
      end else if (d == 8'h0C) begin
        m_cur = 0; m_ovf = 1'b0; m_clear = 1'b1; m_cnt = 0;
      end
    end

    @(posedge clk); #1;
    got = exp_q.pop_front();
    if (got >= 0) check_eq("rd_ascii", bus.rd_ascii, got);
    check_eq("wr_ready", bus.wr_ready, m_clear ? 0 : 1);
    check_eq("cursor", bus.cursor, m_cur);
    check_eq("overflow", bus.overflow, m_ovf);
  endtask

  task automatic send(input logic [7:0] b);
    bus.wr_valid = 1'b1;
    bus.wr_data  = b;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic read_cell(input int idx);
    bus.rd_index = 4'(idx);
    tick();
  endtask

  // Counts cycles until wr_ready rises, bounded so a stuck DUT still finishes.
  task automatic wait_ready(input string tag, input int exp_cycles);
    int n = 0;
    while (bus.wr_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_eq(tag, n, exp_cycles);
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      bus.rd_index = 4'(i);
      tick();
      check_eq(tag, bus.rd_ascii, 8'h00);
    end
  endtask

  initial begin
    logic [7:0] alex [5];
    alex[0] = 8'h41; alex[1] = 8'h6C; alex[2] = 8'h65; alex[3] = 8'h78; alex[4] = 8'h21;
    for (int i = 0; i < 16; i++) begin
      m_known[i] = 1'b0;
      m_mem[i]   = 8'h00;
    end
    m_clear = 1'b0; m_cnt = 0; m_cur = 0; m_ovf = 1'b0;

    // Reset for one cycle with wr_valid held high throughout the clear
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h00;
    bus.rd_index = 4'd0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst_rd_ascii", bus.rd_ascii, 8'h00);
    check_eq("rst_cursor", bus.cursor, 5'd0);
    check_eq("rst_wr_ready", bus.wr_ready, 1'b0);
    wait_ready("ready_after_reset", 16);
    bus.wr_valid = 1'b0;
    read_all_zero("cell_after_reset");

    // Printable text
    for (int i = 0; i < 5; i++) send(alex[i]);
    check_eq("alex_cursor", bus.cursor, 5'd5);
    for (int i = 0; i < 5; i++) begin
      read_cell(i);
      check_eq("alex_cell", bus.rd_ascii, alex[i]);
    end
    read_cell(5);
    check_eq("alex_cell5", bus.rd_ascii, 8'h00);

    // Backspace, including at cursor 0
    send(8'h08);
    send(8'h08);
    check_eq("bs_cursor3", bus.cursor, 5'd3);
    read_cell(3);
    check_eq("bs_cell3", bus.rd_ascii, 8'h00);
    read_cell(4);
    check_eq("bs_cell4", bus.rd_ascii, 8'h00);
    for (int i = 0; i < 4; i++) send(8'h08);
    check_eq("bs_cursor0", bus.cursor, 5'd0);

    // Seventeen printable characters: the 17th lands at cursor 16
    for (int i = 0; i < 17; i++) send(8'h30);
`ifdef TEXT_WRAP_EN
    check_eq("full_cursor", bus.cursor, 5'd1);
    check_eq("full_overflow", bus.overflow, 1'b0);
`else
    check_eq("full_cursor", bus.cursor, 5'd16);
    check_eq("full_overflow", bus.overflow, 1'b1);
`endif
    read_cell(0);
    check_eq("full_cell0", bus.rd_ascii, 8'h30);

    // Move to cursor 7, then form feed
`ifdef TEXT_WRAP_EN
    for (int i = 0; i < 6; i++) send(8'h31);
`else
    for (int i = 0; i < 9; i++) send(8'h08);
    check_eq("pre_ff_overflow", bus.overflow, 1'b1);
`endif
    check_eq("pre_ff_cursor", bus.cursor, 5'd7);
    send(8'h0C);
    check_eq("ff_cursor", bus.cursor, 5'd0);
    check_eq("ff_overflow", bus.overflow, 1'b0);
    wait_ready("ready_after_ff", 16);
    read_all_zero("cell_after_ff");
    send(8'h0A);
    check_eq("lf_cursor", bus.cursor, 5'd0);
    read_cell(0);
    check_eq("lf_cell0", bus.rd_ascii, 8'h00);

    // Reset in the middle of a clear restarts it from cell 0
    send(8'h41);
    send(8'h0C);
    for (int i = 0; i < 8; i++) tick();
    check_eq("mid_clear_ready", bus.wr_ready, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready("ready_after_mid_reset", 16);
    read_all_zero("cell_after_mid_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
